// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush/redirect sequencer:
// stage bit positions, sequencer states and the default interrupt vector.
package pipeline_ctrl_pkg;

  localparam int NUM_STG    = 5;
  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  localparam logic [15:0] INT_VECTOR_DEF = 16'h0004;

  typedef enum logic {
    CTRL_RUN    = 1'b0,
    CTRL_EXWAIT = 1'b1
  } ctrl_state_e;

  typedef logic [NUM_STG-1:0] stg_mask_t;

  function automatic stg_mask_t stg(input int idx);
    return stg_mask_t'(1) << idx;
  endfunction

  localparam stg_mask_t MEM_HOLD   = stg(STG_PC) | stg(STG_IF_ID) | stg(STG_ID_EX) | stg(STG_EX_MEM);
  localparam stg_mask_t MEM_BUBBLE = stg(STG_MEM_WB);
  localparam stg_mask_t EX_HOLD    = stg(STG_PC) | stg(STG_IF_ID) | stg(STG_ID_EX);
  localparam stg_mask_t EX_BUBBLE  = stg(STG_EX_MEM);
  localparam stg_mask_t REDIR_KILL = stg(STG_IF_ID) | stg(STG_ID_EX);
  localparam stg_mask_t ID_HOLD    = stg(STG_PC) | stg(STG_IF_ID);
  localparam stg_mask_t ID_BUBBLE  = stg(STG_ID_EX);

endpackage

// File: rtl/pipeline_ctrl_mc_cnt.sv
// Loadable down-counter tracking the remaining occupancy of a multi-cycle
// EX operation; flags the final wait cycle.
module pipeline_ctrl_mc_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush/redirect sequencer for the 5-stage pipeline: arbitrates
// memory, multi-cycle EX, branch, interrupt, eret and load-use requests.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int              PC_W       = 16,
  parameter int              CNT_W      = 4,
  parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(INT_VECTOR_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_stall_req_i,
  input  logic             ex_start_i,
  input  logic [CNT_W-1:0] ex_cycles_i,
  input  logic             mem_stall_req_i,
  input  logic             branch_i,
  input  logic [PC_W-1:0]  branch_pc_i,
  input  logic             int_req_i,
  input  logic             eret_i,
  input  logic [PC_W-1:0]  id_pc_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       flush_o,
  output logic             new_pc_valid_o,
  output logic [PC_W-1:0]  new_pc_o,
  output logic             int_active_o
);

  ctrl_state_e      state, state_next;
  logic             cnt_load, cnt_dec, cnt_one;
  logic [CNT_W-1:0] cnt;
  logic             int_pending, int_active;
  logic [PC_W-1:0]  epc;
  logic             ex_long, ex_busy;
  logic             int_take, eret_take;
  stg_mask_t        stall, flush;
  logic             pc_valid;
  logic [PC_W-1:0]  pc_next;

  assign ex_long = ex_start_i && (ex_cycles_i >= CNT_W'(2));
  assign ex_busy = (state == CTRL_EXWAIT) || ex_long;

  pipeline_ctrl_mc_cnt #(.CNT_W(CNT_W)) u_mc_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (cnt_load),
    .load_val (ex_cycles_i - CNT_W'(2)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .is_one   (cnt_one)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      CTRL_RUN: begin
        if (ex_long) begin
          cnt_load = 1'b1;
          if (ex_cycles_i != CNT_W'(2)) state_next = CTRL_EXWAIT;
        end
      end
      CTRL_EXWAIT: begin
        // Counts down even while a memory stall masks the EX stall.
        cnt_dec = 1'b1;
        if (cnt_one) state_next = CTRL_RUN;
      end
      default: state_next = CTRL_RUN;
    endcase
  end

  always_comb begin
    stall     = '0;
    flush     = '0;
    pc_valid  = 1'b0;
    pc_next   = '0;
    int_take  = 1'b0;
    eret_take = 1'b0;
    if (rst_i) begin
      stall = '0;
    end else if (mem_stall_req_i) begin
      stall = MEM_HOLD;
      flush = MEM_BUBBLE;
    end else if (ex_busy) begin
      stall = EX_HOLD;
      flush = EX_BUBBLE;
    end else if (branch_i) begin
      flush    = REDIR_KILL;
      pc_valid = 1'b1;
      pc_next  = branch_pc_i;
    end else if (int_pending && state == CTRL_RUN) begin
      int_take = 1'b1;
      flush    = REDIR_KILL;
      pc_valid = 1'b1;
      pc_next  = INT_VECTOR;
    end else if (eret_i && int_active) begin
      eret_take = 1'b1;
      flush     = REDIR_KILL;
      pc_valid  = 1'b1;
      pc_next   = epc;
    end else if (id_stall_req_i) begin
      stall = ID_HOLD;
      flush = ID_BUBBLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= CTRL_RUN;
      int_pending <= 1'b0;
      int_active  <= 1'b0;
      epc         <= '0;
    end else begin
      state <= state_next;
      if (int_take) begin
        epc         <= id_pc_i;
        int_active  <= 1'b1;
        int_pending <= 1'b0;
      end else if (int_req_i && (!int_active || eret_take)) begin
        // A request arriving with the eret is kept, since the mask drops at this edge.
        int_pending <= 1'b1;
      end
      if (eret_take) int_active <= 1'b0;
    end
  end

  assign stall_o        = stall;
  assign flush_o        = flush;
  assign new_pc_valid_o = pc_valid;
  assign new_pc_o       = pc_next;
  assign int_active_o   = int_active;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected per-cycle controls are queued
// as stimulus is applied and compared against the DUT at the falling edge.
module tb_pipeline_ctrl;

  localparam int PC_W  = 16;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [4:0]      stall;
    logic [4:0]      flush;
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            act;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             id_stall_req_i, ex_start_i, mem_stall_req_i, branch_i, int_req_i, eret_i;
  logic [CNT_W-1:0] ex_cycles_i;
  logic [PC_W-1:0]  branch_pc_i, id_pc_i;
  logic [4:0]       stall_o, flush_o;
  logic             new_pc_valid_o, int_active_o;
  logic [PC_W-1:0]  new_pc_o;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  pipeline_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .INT_VECTOR(16'h0004)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id_stall_req_i  (id_stall_req_i),
    .ex_start_i      (ex_start_i),
    .ex_cycles_i     (ex_cycles_i),
    .mem_stall_req_i (mem_stall_req_i),
    .branch_i        (branch_i),
    .branch_pc_i     (branch_pc_i),
    .int_req_i       (int_req_i),
    .eret_i          (eret_i),
    .id_pc_i         (id_pc_i),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_valid_o  (new_pc_valid_o),
    .new_pc_o        (new_pc_o),
    .int_active_o    (int_active_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] s, input logic [4:0] f, input logic v,
                              input logic [PC_W-1:0] pc, input logic a);
    exp_t e;
    e.stall = s; e.flush = f; e.valid = v; e.pc = pc; e.act = a;
    return e;
  endfunction

  task automatic idle();
    id_stall_req_i = 1'b0; ex_start_i = 1'b0; ex_cycles_i = '0; mem_stall_req_i = 1'b0;
    branch_i = 1'b0; branch_pc_i = '0; int_req_i = 1'b0; eret_i = 1'b0;
  endtask

  // Queue the expectation for the inputs now applied, compare at the falling
  // edge, then return just after the next rising edge ready for new stimulus.
  task automatic step(input string tag, input exp_t e);
    exp_t want;
    exp_q.push_back(e);
    @(negedge clk_i);
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      want = exp_q.pop_front();
      check({tag, ".stall"}, 32'(stall_o), 32'(want.stall));
      check({tag, ".flush"}, 32'(flush_o), 32'(want.flush));
      check({tag, ".valid"}, 32'(new_pc_valid_o), 32'(want.valid));
      check({tag, ".pc"}, 32'(new_pc_o), 32'(want.pc));
      check({tag, ".act"}, 32'(int_active_o), 32'(want.act));
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t z, ex_st, mem_st;
    z      = mk(5'b00000, 5'b00000, 1'b0, 16'h0000, 1'b0);
    ex_st  = mk(5'b00111, 5'b01000, 1'b0, 16'h0000, 1'b0);
    mem_st = mk(5'b01111, 5'b10000, 1'b0, 16'h0000, 1'b0);
    idle();
    id_pc_i = 16'h0000;

    // Reset masks all outputs even with requests asserted.
    rst_i = 1'b1; id_stall_req_i = 1'b1; mem_stall_req_i = 1'b1; branch_i = 1'b1;
    step("rst", z);
    rst_i = 1'b0; idle();
    step("idle", z);

    // Load-use stall for one cycle.
    id_stall_req_i = 1'b1;
    step("ld_use", mk(5'b00011, 5'b00100, 1'b0, 16'h0000, 1'b0));
    idle();
    step("ld_use_after", z);

    // Multi-cycle EX: N-1 stall cycles for N = 4, 1, 2.
    ex_start_i = 1'b1; ex_cycles_i = 4'd4;
    step("n4_c0", ex_st);
    idle();
    step("n4_c1", ex_st);
    step("n4_c2", ex_st);
    step("n4_c3", z);
    ex_start_i = 1'b1; ex_cycles_i = 4'd1;
    step("n1_c0", z);
    idle();
    step("n1_c1", z);
    ex_start_i = 1'b1; ex_cycles_i = 4'd2;
    step("n2_c0", ex_st);
    idle();
    step("n2_c1", z);

    // Branch beats load-use stall.
    branch_i = 1'b1; branch_pc_i = 16'h0040; id_stall_req_i = 1'b1;
    step("branch", mk(5'b00000, 5'b00110, 1'b1, 16'h0040, 1'b0));
    idle();
    step("branch_after", z);

    // Memory stall inside an N = 5 wait; branch held across the EX stall.
    ex_start_i = 1'b1; ex_cycles_i = 4'd5;
    step("n5_c0", ex_st);
    idle(); mem_stall_req_i = 1'b1;
    step("n5_mem1", mem_st);
    step("n5_mem2", mem_st);
    idle(); branch_i = 1'b1; branch_pc_i = 16'h0080;
    step("n5_c3_br", ex_st);
    step("n5_c4_br", mk(5'b00000, 5'b00110, 1'b1, 16'h0080, 1'b0));
    idle();
    step("n5_after", z);

    // eret without an active handler falls through to the load-use row.
    eret_i = 1'b1; id_stall_req_i = 1'b1;
    step("eret_idle", mk(5'b00011, 5'b00100, 1'b0, 16'h0000, 1'b0));
    idle();

    // Interrupt entry, masked second request, and return.
    id_pc_i = 16'h0012; int_req_i = 1'b1;
    step("int_req", z);
    idle();
    step("int_take", mk(5'b00000, 5'b00110, 1'b1, 16'h0004, 1'b0));
    id_pc_i = 16'h0020;
    step("int_in", mk(5'b00000, 5'b00000, 1'b0, 16'h0000, 1'b1));
    int_req_i = 1'b1;
    step("int_req2", mk(5'b00000, 5'b00000, 1'b0, 16'h0000, 1'b1));
    idle();
    step("int_masked", mk(5'b00000, 5'b00000, 1'b0, 16'h0000, 1'b1));
    eret_i = 1'b1;
    step("eret", mk(5'b00000, 5'b00110, 1'b1, 16'h0012, 1'b1));
    idle();
    step("eret_after", z);
    step("eret_quiet", z);

    // Asynchronous reset in the middle of an EX wait.
    ex_start_i = 1'b1; ex_cycles_i = 4'd6;
    step("n6_c0", ex_st);
    idle();
    step("n6_c1", ex_st);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst.stall", 32'(stall_o), 32'd0);
    check("async_rst.flush", 32'(flush_o), 32'd0);
    check("async_rst.valid", 32'(new_pc_valid_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    id_stall_req_i = 1'b1;
    step("post_rst_ld_use", mk(5'b00011, 5'b00100, 1'b0, 16'h0000, 1'b0));
    idle();
    step("post_rst_idle", z);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
